// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Frame-rate ball-and-paddle game controller. Owns ball
//               position and velocity, both scores and the
//               IDLE/SERVE/PLAY/SCORE/GAME_OVER sequence. Advances once per
//               frame_tick, and all outputs are registered.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         : system clock
//   rst         : asynchronous reset, active low
//   frame_tick  : one-cycle pulse per frame, at the start of vertical blanking
//   start       : begins a game from IDLE or GAME_OVER
//   mode        : 00 tennis, 01 football, 10 squash, 11 practice
//   bat_size    : paddle half-height is 35 when 1, 25 when 0
//   p1_y, p2_y  : paddle centre rows
//   ball_x/y    : ball centre (the 8x8 ball spans centre-4 .. centre+3)
//   p1/p2_score : scores, saturating at 31
//   state       : 0 IDLE, 1 SERVE, 2 PLAY, 3 SCORE, 4 GAME_OVER
//   game_over   : high while in GAME_OVER
// Configuration
//   GAME_SEQUENCER_SPEEDUP_EN : when defined, every 4th paddle hit in a rally
//                               adds 1 to the ball speed, up to 6.
// ============================================================================
module game_sequencer #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_FRAMES = 90,
  parameter int BALL_SPEED   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        bat_size,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [4:0]  p1_score,
  output logic [4:0]  p2_score,
  output logic [2:0]  state,
  output logic        game_over
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_SCORE     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam int CNT_MAX = (SERVE_FRAMES > SCORE_FRAMES) ? SERVE_FRAMES : SCORE_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_serve_last = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_score_last = CNT_W'(SCORE_FRAMES - 1);
  localparam logic [2:0]       c_ball_speed = 3'(BALL_SPEED);
  localparam logic [4:0]       c_win_score  = 5'(WIN_SCORE);
  localparam logic [10:0]      c_centre_x   = 11'd320;
  localparam logic [10:0]      c_centre_y   = 11'd240;

  state_t           r_state;
  logic [10:0]      r_ball_x;
  logic [10:0]      r_ball_y;
  logic [4:0]       r_p1_score;
  logic [4:0]       r_p2_score;
  logic             r_game_over;
  logic             r_dx;          // 1 = moving right (+)
  logic             r_dy;          // 1 = moving down (+)
  logic             r_serve_dx;    // direction of the next serve in two-player modes
  logic             r_serve_dy;    // alternates on every serve
  // Modes 00 and 01 share identical rules, so only the single-player bit of
  // the latched mode affects behaviour.
  logic             r_single;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [2:0]       w_speed;

`ifdef GAME_SEQUENCER_SPEEDUP_EN
  logic [2:0]       r_speed;
  logic [1:0]       r_hit_cnt;
  logic             w_hit;
  assign w_speed = r_speed;
`else
  assign w_speed = c_ball_speed;
`endif

  // Paddle overlap test, done in 13-bit signed so py-size cannot wrap.
  function automatic logic overlap(input logic [10:0] by, input logic [10:0] py,
                                   input logic big);
    logic signed [12:0] size;
    logic signed [12:0] b;
    logic signed [12:0] p;
    size = big ? 13'sd35 : 13'sd25;
    b    = $signed({2'b00, by});
    p    = $signed({2'b00, py});
    return ((b + 13'sd4) > (p - size)) && ((b - 13'sd4) < (p + size));
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] s);
    return (s == 5'd31) ? 5'd31 : s + 5'd1;
  endfunction

  logic [11:0]        w_step;
  logic signed [11:0] w_bx;
  logic signed [11:0] w_by;
  logic signed [11:0] w_nx;
  logic signed [11:0] w_ny;
  logic               w_ov1;
  logic               w_ov2;
  logic               w_p1_hit;
  logic               w_p2_hit;
  logic               w_fwd_hit;
  logic [4:0]         w_p1_inc;
  logic [4:0]         w_p2_inc;

  assign w_step    = {9'd0, w_speed};
  assign w_bx      = $signed({1'b0, r_ball_x});
  assign w_by      = $signed({1'b0, r_ball_y});
  assign w_nx      = r_dx ? (w_bx + $signed(w_step)) : (w_bx - $signed(w_step));
  assign w_ny      = r_dy ? (w_by + $signed(w_step)) : (w_by - $signed(w_step));
  assign w_ov1     = overlap(r_ball_y, p1_y, bat_size);
  assign w_ov2     = overlap(r_ball_y, p2_y, bat_size);
  assign w_p1_hit  = !r_dx && (w_bx >= 12'sd50) && (w_nx < 12'sd50) && w_ov1;
  assign w_p2_hit  =  r_dx && (w_bx <= 12'sd590) && (w_nx > 12'sd590) && w_ov2;
  assign w_fwd_hit =  r_dx && (w_bx <= 12'sd480) && (w_nx > 12'sd480) && w_ov1;
  assign w_p1_inc  = sat_inc(r_p1_score);
  assign w_p2_inc  = sat_inc(r_p2_score);

`ifdef GAME_SEQUENCER_SPEEDUP_EN
  assign w_hit = r_single ? w_fwd_hit : (w_p1_hit || w_p2_hit);
`endif

  // Result of one PLAY frame. Wall and paddle/score effects are independent,
  // so both are applied when they coincide.
  logic [10:0] w_next_x;
  logic [10:0] w_next_y;
  logic        w_next_dx;
  logic        w_next_dy;
  logic [4:0]  w_next_p1;
  logic [4:0]  w_next_p2;
  logic        w_next_serve_dx;
  state_t      w_next_state;

  always_comb begin
    w_next_x        = w_nx[10:0];
    w_next_y        = w_ny[10:0];
    w_next_dx       = r_dx;
    w_next_dy       = r_dy;
    w_next_p1       = r_p1_score;
    w_next_p2       = r_p2_score;
    w_next_serve_dx = r_serve_dx;
    w_next_state    = ST_PLAY;

    if (w_ny < 12'sd30) begin
      w_next_y  = 11'd30;
      w_next_dy = 1'b1;
    end else if (w_ny > 12'sd450) begin
      w_next_y  = 11'd450;
      w_next_dy = 1'b0;
    end

    if (!r_single) begin
      if (w_p1_hit) begin
        w_next_x  = 11'd50;
        w_next_dx = 1'b1;
      end else if (w_p2_hit) begin
        w_next_x  = 11'd590;
        w_next_dx = 1'b0;
      end
      // The next serve goes toward whoever lost the point.
      if (w_nx <= 12'sd24) begin
        w_next_p2       = w_p2_inc;
        w_next_serve_dx = 1'b0;
        w_next_state    = (w_p2_inc == c_win_score) ? ST_GAME_OVER : ST_SCORE;
      end else if (w_nx >= 12'sd616) begin
        w_next_p1       = w_p1_inc;
        w_next_serve_dx = 1'b1;
        w_next_state    = (w_p1_inc == c_win_score) ? ST_GAME_OVER : ST_SCORE;
      end
    end else begin
      if (w_nx < 12'sd30) begin
        w_next_x  = 11'd30;
        w_next_dx = 1'b1;
      end else if (w_fwd_hit) begin
        w_next_x  = 11'd480;
        w_next_dx = 1'b0;
        w_next_p1 = w_p1_inc;
      end
      if (w_nx >= 12'sd616) begin
        w_next_state = ST_GAME_OVER;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ball_x    <= c_centre_x;
      r_ball_y    <= c_centre_y;
      r_p1_score  <= 5'd0;
      r_p2_score  <= 5'd0;
      r_game_over <= 1'b0;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_serve_dx  <= 1'b1;
      r_serve_dy  <= 1'b1;
      r_single    <= 1'b0;
      r_frame_cnt <= '0;
`ifdef GAME_SEQUENCER_SPEEDUP_EN
      r_speed     <= c_ball_speed;
      r_hit_cnt   <= 2'd0;
`endif
    end else begin
      case (r_state)
        // start takes priority over a coincident frame_tick here.
        ST_IDLE, ST_GAME_OVER: begin
          if (start) begin
            r_state     <= ST_SERVE;
            r_p1_score  <= 5'd0;
            r_p2_score  <= 5'd0;
            r_single    <= mode[1];
            r_ball_x    <= c_centre_x;
            r_ball_y    <= c_centre_y;
            r_frame_cnt <= '0;
            r_game_over <= 1'b0;
`ifdef GAME_SEQUENCER_SPEEDUP_EN
            r_speed     <= c_ball_speed;
            r_hit_cnt   <= 2'd0;
`endif
          end
        end

        ST_SERVE: begin
          if (frame_tick) begin
            if (r_frame_cnt == c_serve_last) begin
              r_state     <= ST_PLAY;
              r_frame_cnt <= '0;
              r_dx        <= r_single ? 1'b0 : r_serve_dx;
              r_dy        <= r_serve_dy;
              r_serve_dy  <= ~r_serve_dy;
            end else begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
          end
        end

        ST_PLAY: begin
          if (frame_tick) begin
            r_ball_x    <= w_next_x;
            r_ball_y    <= w_next_y;
            r_dx        <= w_next_dx;
            r_dy        <= w_next_dy;
            r_p1_score  <= w_next_p1;
            r_p2_score  <= w_next_p2;
            r_serve_dx  <= w_next_serve_dx;
            r_state     <= w_next_state;
            r_game_over <= (w_next_state == ST_GAME_OVER);
            r_frame_cnt <= '0;
`ifdef GAME_SEQUENCER_SPEEDUP_EN
            if (w_hit) begin
              r_hit_cnt <= r_hit_cnt + 2'd1;
              if ((r_hit_cnt == 2'd3) && (r_speed < 3'd6)) begin
                r_speed <= r_speed + 3'd1;
              end
            end
`endif
          end
        end

        ST_SCORE: begin
          if (frame_tick) begin
            if (r_frame_cnt == c_score_last) begin
              r_state     <= ST_SERVE;
              r_frame_cnt <= '0;
              r_ball_x    <= c_centre_x;
              r_ball_y    <= c_centre_y;
`ifdef GAME_SEQUENCER_SPEEDUP_EN
              r_speed     <= c_ball_speed;
              r_hit_cnt   <= 2'd0;
`endif
            end else begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ball_x    = r_ball_x;
  assign ball_y    = r_ball_y;
  assign p1_score  = r_p1_score;
  assign p2_score  = r_p2_score;
  assign state     = r_state;
  assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed testbench for game_sequencer. Plays five rallies
//               with paddle positions chosen so every hit, miss, wall bounce
//               and score lands on a hand-computed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        start;
  logic [1:0]  mode;
  logic        bat_size;
  logic [10:0] p1_y;
  logic [10:0] p2_y;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [4:0]  p1_score;
  logic [4:0]  p2_score;
  logic [2:0]  state;
  logic        game_over;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;   // PLAY ticks in the current rally

  always #5 clk = ~clk;

  game_sequencer #(
    .WIN_SCORE   (3),
    .SERVE_FRAMES(60),
    .SCORE_FRAMES(90),
    .BALL_SPEED  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .frame_tick(frame_tick),
    .start     (start),
    .mode      (mode),
    .bat_size  (bat_size),
    .p1_y      (p1_y),
    .p2_y      (p2_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .state     (state),
    .game_over (game_over)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick; returns on the following falling edge with outputs settled.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic play_to(input int target);
    while (k < target) begin
      tick();
      k++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check_value({tag, "_x"}, 32'(ball_x), 32'(x));
    check_value({tag, "_y"}, 32'(ball_y), 32'(y));
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    mode       = 2'b00;
    bat_size   = 1'b0;
    p1_y       = 11'd600;
    p2_y       = 11'd1000;
    repeat (3) @(negedge clk);

    check_value("rst_state", 32'(state), 0);
    check_pos("rst", 320, 240);
    check_value("rst_p1", 32'(p1_score), 0);
    check_value("rst_p2", 32'(p2_score), 0);
    check_value("rst_go", 32'(game_over), 0);
    rst_n = 1'b1;

    tick();
    check_value("idle_tick", 32'(state), 0);

    // start and frame_tick together: start wins, the tick is not counted.
    @(negedge clk) begin start = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin start = 1'b0; frame_tick = 1'b0; end
    check_value("start_state", 32'(state), 1);
    ticks(30);
    pulse_start();
    check_value("serve_start_ign", 32'(state), 1);
    ticks(29);
    check_value("serve_59", 32'(state), 1);
    tick();
    check_value("serve_60", 32'(state), 2);
    check_pos("serve_pos", 320, 240);

    // Rally 1: serve +,+ ; P2 misses. mode input changes mid-game (no effect).
    mode = 2'b10;
    k = 0;
    play_to(1);   check_pos("r1_k1", 322, 242);
    play_to(105); check_value("r1_k105_y", 32'(ball_y), 450);
    play_to(106); check_pos("r1_wall", 532, 450);
    play_to(107); check_value("r1_k107_y", 32'(ball_y), 448);
    play_to(147); check_value("r1_k147_st", 32'(state), 2);
    play_to(148);
    check_value("r1_point_st", 32'(state), 3);
    check_value("r1_point_p1", 32'(p1_score), 1);
    check_value("r1_point_p2", 32'(p2_score), 0);
    ticks(45);
    pulse_start();
    ticks(44);
    check_value("score_89", 32'(state), 3);
    tick();
    check_value("score_90", 32'(state), 1);
    check_pos("recentre", 320, 240);
    ticks(60);
    check_value("r2_play", 32'(state), 2);

    // Rally 2: serve +,- ; floor bounce, P2 hit, P1 edge hit with big bat, P2 miss.
    mode = 2'b00; p2_y = 11'd88; p1_y = 11'd301; bat_size = 1'b1;
    k = 0;
    play_to(1);   check_pos("r2_k1", 322, 238);
    play_to(105); check_value("r2_k105_y", 32'(ball_y), 30);
    play_to(106); check_value("r2_wall_y", 32'(ball_y), 30);
    play_to(107); check_value("r2_k107_y", 32'(ball_y), 32);
    play_to(136); check_pos("r2_p2hit", 590, 90);
    play_to(137); check_value("r2_k137_x", 32'(ball_x), 588);
    play_to(407); check_pos("r2_p1hit", 50, 270);
    play_to(408); check_pos("r2_k408", 52, 268);
    play_to(690);
    check_value("r2_point_st", 32'(state), 3);
    check_value("r2_point_p1", 32'(p1_score), 2);
    ticks(90);
    ticks(60);
    check_value("r3_play", 32'(state), 2);

    // Rally 3: serve +,+ ; P2 hits, P1 misses.
    p2_y = 11'd392; p1_y = 11'd600; bat_size = 1'b0;
    k = 0;
    play_to(136); check_pos("r3_p2hit", 590, 390);
    play_to(137); check_value("r3_k137_x", 32'(ball_x), 588);
    play_to(418); check_value("r3_k418_st", 32'(state), 2);
    play_to(419);
    check_value("r3_point_st", 32'(state), 3);
    check_value("r3_point_p2", 32'(p2_score), 1);
    check_value("r3_point_p1", 32'(p1_score), 2);
    ticks(150);
    check_value("r4_play", 32'(state), 2);

    // Rally 4: serve toward P1 (-,-) ; P1 hits, P2 misses -> winning point.
    p1_y = 11'd88; p2_y = 11'd1000;
    k = 0;
    play_to(1);   check_pos("r4_k1", 318, 238);
    play_to(136); check_pos("r4_p1hit", 50, 90);
    play_to(137); check_value("r4_k137_x", 32'(ball_x), 52);
    play_to(418); check_value("r4_k418_st", 32'(state), 2);
    play_to(419);
    check_value("win_st", 32'(state), 4);
    check_value("win_p1", 32'(p1_score), 3);
    check_value("win_go", 32'(game_over), 1);
    tick();
    check_value("go_tick", 32'(state), 4);

    // Rally 5: squash mode, serve always -, dy +.
    mode = 2'b10;
    pulse_start();
    check_value("restart_st", 32'(state), 1);
    check_value("restart_p1", 32'(p1_score), 0);
    check_value("restart_p2", 32'(p2_score), 0);
    check_value("restart_go", 32'(game_over), 0);
    check_pos("restart", 320, 240);
    mode = 2'b00; p1_y = 11'd138; p2_y = 11'd138;
    ticks(60);
    check_value("r5_play", 32'(state), 2);
    k = 0;
    play_to(1);   check_pos("r5_k1", 318, 242);
    play_to(145); check_value("r5_k145_x", 32'(ball_x), 30);
    play_to(146); check_value("r5_lwall_x", 32'(ball_x), 30);
    play_to(147); check_value("r5_k147_x", 32'(ball_x), 32);
    play_to(372);
    check_pos("r5_fwd", 480, 140);
    check_value("r5_fwd_p1", 32'(p1_score), 1);
    p1_y = 11'd1000;
    play_to(373); check_value("r5_k373_x", 32'(ball_x), 478);
    play_to(890); check_value("r5_k890_st", 32'(state), 2);
    play_to(891);
    check_value("r5_miss_st", 32'(state), 4);
    check_value("r5_miss_go", 32'(game_over), 1);
    check_value("r5_miss_p1", 32'(p1_score), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
